// File: rtl/instr_encoder.sv
// Instruction encoder: turns symbolic {opcode, operand} beats into 16-bit
// {opcode[5:0], info[9:0]} words and writes them sequentially into
// instruction memory. Branch targets are made PC-relative for the decoder.
// Opcode values mirror the instrDefine.v macro set.
// Optional feature macro: NOP_PAD_EN (pad the rest of memory with NOPs).
module instr_encoder #(
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_opcode,
  input  logic [9:0]  in_operand,
  input  logic        in_last,
  output logic        mem_we,
  output logic [9:0]  mem_addr,
  output logic [15:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [9:0]  count
);

  localparam logic [5:0] OpNop   = 6'd0;
  localparam logic [5:0] OpLda   = 6'd1;
  localparam logic [5:0] OpLdb   = 6'd2;
  localparam logic [5:0] OpSta   = 6'd3;
  localparam logic [5:0] OpStb   = 6'd4;
  localparam logic [5:0] OpLdca  = 6'd5;
  localparam logic [5:0] OpLdcb  = 6'd6;
  localparam logic [5:0] OpJmp   = 6'd7;
  localparam logic [5:0] OpAdda  = 6'd8;
  localparam logic [5:0] OpAddb  = 6'd9;
  localparam logic [5:0] OpSuba  = 6'd10;
  localparam logic [5:0] OpSubb  = 6'd11;
  localparam logic [5:0] OpAnda  = 6'd12;
  localparam logic [5:0] OpOra   = 6'd13;
  localparam logic [5:0] OpNota  = 6'd14;
  localparam logic [5:0] OpAsra  = 6'd15;
  localparam logic [5:0] OpAddca = 6'd16;
  localparam logic [5:0] OpAddcb = 6'd17;
  localparam logic [5:0] OpSubca = 6'd18;
  localparam logic [5:0] OpSubcb = 6'd19;
  localparam logic [5:0] OpAndca = 6'd20;
  localparam logic [5:0] OpAndcb = 6'd21;
  localparam logic [5:0] OpOrca  = 6'd22;
  localparam logic [5:0] OpOrcb  = 6'd23;
  localparam logic [5:0] OpBaeq  = 6'd32;
  localparam logic [5:0] OpBane  = 6'd33;
  localparam logic [5:0] OpBacs  = 6'd34;
  localparam logic [5:0] OpBacc  = 6'd35;
  localparam logic [5:0] OpBami  = 6'd36;
  localparam logic [5:0] OpBapl  = 6'd37;
  localparam logic [5:0] OpBbeq  = 6'd40;
  localparam logic [5:0] OpBbne  = 6'd41;
  localparam logic [5:0] OpBbcs  = 6'd42;
  localparam logic [5:0] OpBbcc  = 6'd43;
  localparam logic [5:0] OpBbmi  = 6'd44;
  localparam logic [5:0] OpBbpl  = 6'd45;

  localparam logic [9:0] BaseAddr = 10'(BASE_ADDR);
  localparam logic [9:0] LastAddr = 10'(MEM_DEPTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
`ifdef NOP_PAD_EN
    StPad,
`endif
    StDone,
    StError
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  wptr_q, wptr_d;
  logic [9:0]  count_q, count_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        mem_we_q, mem_we_d;
  logic [9:0]  mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        done_q, done_d;
  // fin: the final word is on the write port this cycle; DONE follows.
  logic        fin_q, fin_d;
  // full: a word has been written at the last address; any further beat overflows.
  logic        full_q, full_d;

  logic [9:0]  enc_info;
  logic [1:0]  enc_fault;
  logic [10:0] rel;
  logic        accept;

  assign in_ready  = (state_q == StLoad) && !fin_q;
  assign accept    = in_valid && in_ready;
`ifdef NOP_PAD_EN
  assign busy      = (state_q == StLoad) || (state_q == StPad);
`else
  assign busy      = (state_q == StLoad);
`endif
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign count     = count_q;

  // Classify the incoming opcode and build its info field or fault code.
  always_comb begin
    enc_info  = in_operand;
    enc_fault = 2'b00;
    // Target relative to the PC after this word, as the decoder adds it.
    rel       = {1'b0, in_operand} - ({1'b0, wptr_q} + 11'd1);
    if (full_q) begin
      enc_fault = 2'b11;
    end else begin
      case (in_opcode)
        OpJmp, OpSta, OpStb,
        OpNop, OpLda, OpLdb,
        OpAdda, OpAddb, OpSuba, OpSubb, OpAnda, OpOra, OpNota, OpAsra: begin
          enc_info = in_operand;
        end
        OpLdca, OpLdcb, OpAddca, OpAddcb, OpSubca, OpSubcb,
        OpAndca, OpAndcb, OpOrca, OpOrcb: begin
          enc_info = {2'b00, in_operand[7:0]};
          if (in_operand[9:8] != 2'b00) enc_fault = 2'b01;
        end
        OpBaeq, OpBane, OpBacs, OpBacc, OpBami, OpBapl,
        OpBbeq, OpBbne, OpBbcs, OpBbcc, OpBbmi, OpBbpl: begin
          enc_info = {4'b0000, rel[5:0]};
          // Backward targets wrap to large values and fail here too.
          if (rel[10:6] != 5'd0) enc_fault = 2'b10;
        end
        default: enc_fault = 2'b11;
      endcase
    end
  end

  // Next-state, write-port and status logic.
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    count_d     = count_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    fin_d       = fin_q;
    full_d      = full_q;

    if (start) begin
      state_d    = StLoad;
      wptr_d     = BaseAddr;
      count_d    = 10'd0;
      err_d      = 1'b0;
      err_code_d = 2'b00;
      fin_d      = 1'b0;
      full_d     = 1'b0;
    end else begin
      case (state_q)
        StLoad: begin
          if (fin_q) begin
            state_d = StDone;
            done_d  = 1'b1;
            fin_d   = 1'b0;
          end else if (accept) begin
            if (enc_fault != 2'b00) begin
              state_d    = StError;
              err_d      = 1'b1;
              err_code_d = enc_fault;
            end else begin
              mem_we_d    = 1'b1;
              mem_addr_d  = wptr_q;
              mem_wdata_d = {in_opcode, enc_info};
              count_d     = count_q + 10'd1;
              if (wptr_q == LastAddr) full_d = 1'b1;
              else                    wptr_d = wptr_q + 10'd1;
              if (in_last) begin
`ifdef NOP_PAD_EN
                if (wptr_q == LastAddr) fin_d = 1'b1;
                else                    state_d = StPad;
`else
                fin_d = 1'b1;
`endif
              end
            end
          end
        end
`ifdef NOP_PAD_EN
        StPad: begin
          if (fin_q) begin
            state_d = StDone;
            done_d  = 1'b1;
            fin_d   = 1'b0;
          end else begin
            mem_we_d    = 1'b1;
            mem_addr_d  = wptr_q;
            mem_wdata_d = {OpNop, 10'd0};
            count_d     = count_q + 10'd1;
            if (wptr_q == LastAddr) begin
              full_d = 1'b1;
              fin_d  = 1'b1;
            end else begin
              wptr_d = wptr_q + 10'd1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      wptr_q      <= BaseAddr;
      count_q     <= 10'd0;
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 10'd0;
      mem_wdata_q <= 16'd0;
      done_q      <= 1'b0;
      fin_q       <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      count_q     <= count_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      fin_q       <= fin_d;
      full_q      <= full_d;
    end
  end

endmodule
